// File: rtl/debug_pkg.sv
// Shared definitions for the debug dump path: FSM state encoding, byte-count
// derivation and database entry select constants.
package debug_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECT   = 3'd1,
    LOAD     = 3'd2,
    SEND     = 3'd3,
    WAIT_TX  = 3'd4,
    DONE     = 3'd5,
    CHECKSUM = 3'd6
  } state_t;

  localparam logic [2:0] DB_PC          = 3'd0;
  localparam logic [2:0] DB_ADDER_PC    = 3'd1;
  localparam logic [2:0] DB_CICLOS      = 3'd2;
  localparam logic [2:0] DB_INSTRUCTION = 3'd3;

  function automatic int unsigned calc_nb(input int unsigned word_w, input int unsigned byte_w);
    return word_w / byte_w;
  endfunction

endpackage

// File: rtl/debug_tx_sequencer_word_serializer.sv
// Holds one database word and hands it out byte by byte, LSB first.
// next_byte is the byte that becomes current after the pending load/shift.
module word_serializer
  import debug_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  output logic [BYTE_W-1:0] next_byte,
  output logic              last
);

  localparam int unsigned NB = calc_nb(WORD_W, BYTE_W);
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

  logic [WORD_W-1:0] shift_reg;
  logic [CW-1:0]     byte_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      byte_cnt  <= '0;
    end else if (load) begin
      shift_reg <= din;
      byte_cnt  <= '0;
    end else if (shift) begin
      shift_reg <= shift_reg >> BYTE_W;
      byte_cnt  <= byte_cnt + 1'b1;
    end
  end

  generate
    if (NB > 1) begin : g_multi
      always_comb next_byte = load ? din[BYTE_W-1:0] : shift_reg[2*BYTE_W-1:BYTE_W];
    end else begin : g_single
      always_comb next_byte = din[BYTE_W-1:0];
    end
  endgenerate

  assign last = (byte_cnt == CW'(NB - 1));

endmodule

// File: rtl/debug_tx_sequencer.sv
// Dumps CANT_DATOS database words to the UART transmitter, LSB byte first.
// Optional DEBUG_TX_CHECKSUM_EN appends one XOR checksum byte to each dump.
module debug_tx_sequencer
  import debug_pkg::*;
#(
  parameter int unsigned LONGITUD_INSTRUCCION = 32,
  parameter int unsigned OUTPUT_WORD_LENGTH   = 8,
  parameter int unsigned CANT_BITS_CONTROL    = 3,
  parameter int unsigned CANT_DATOS           = 4
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_start,
  input  logic                            i_tx_done,
  input  logic [LONGITUD_INSTRUCCION-1:0] i_dato_database,
  output logic [CANT_BITS_CONTROL-1:0]    o_control_database,
  output logic                            o_tx_start,
  output logic [OUTPUT_WORD_LENGTH-1:0]   o_data_tx,
  output logic                            o_busy,
  output logic                            o_done
);

  localparam logic [CANT_BITS_CONTROL-1:0] LAST_WORD = CANT_BITS_CONTROL'(CANT_DATOS - 1);

  state_t                          state, state_n;
  logic [CANT_BITS_CONTROL-1:0]    word_n;
  logic                            tx_start_n, busy_n, done_n;
  logic [OUTPUT_WORD_LENGTH-1:0]   data_n;
  logic                            ser_load, ser_shift, ser_last;
  logic [OUTPUT_WORD_LENGTH-1:0]   ser_next;
`ifdef DEBUG_TX_CHECKSUM_EN
  logic [OUTPUT_WORD_LENGTH-1:0]   csum_q, csum_n;
`endif

  word_serializer #(
    .WORD_W(LONGITUD_INSTRUCCION),
    .BYTE_W(OUTPUT_WORD_LENGTH)
  ) u_serializer (
    .clk      (i_clock),
    .rst      (i_reset),
    .load     (ser_load),
    .shift    (ser_shift),
    .din      (i_dato_database),
    .next_byte(ser_next),
    .last     (ser_last)
  );

  // o_control_database doubles as the word index; every output is a register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state              <= IDLE;
      o_control_database <= '0;
      o_tx_start         <= 1'b0;
      o_data_tx          <= '0;
      o_busy             <= 1'b0;
      o_done             <= 1'b0;
`ifdef DEBUG_TX_CHECKSUM_EN
      csum_q             <= '0;
`endif
    end else begin
      state              <= state_n;
      o_control_database <= word_n;
      o_tx_start         <= tx_start_n;
      o_data_tx          <= data_n;
      o_busy             <= busy_n;
      o_done             <= done_n;
`ifdef DEBUG_TX_CHECKSUM_EN
      csum_q             <= csum_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    word_n     = o_control_database;
    tx_start_n = 1'b0;
    data_n     = o_data_tx;
    busy_n     = o_busy;
    done_n     = 1'b0;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
`ifdef DEBUG_TX_CHECKSUM_EN
    csum_n     = csum_q;
`endif
    case (state)
      IDLE: begin
        if (i_start) begin
          state_n = SELECT;
          busy_n  = 1'b1;
          word_n  = '0;
`ifdef DEBUG_TX_CHECKSUM_EN
          csum_n  = '0;
`endif
        end
      end
      SELECT: state_n = LOAD;
      LOAD: begin
        ser_load   = 1'b1;
        state_n    = SEND;
        tx_start_n = 1'b1;
        data_n     = ser_next;
`ifdef DEBUG_TX_CHECKSUM_EN
        csum_n     = csum_q ^ ser_next;
`endif
      end
      SEND: state_n = WAIT_TX;
      WAIT_TX: begin
        if (i_tx_done) begin
          if (!ser_last) begin
            ser_shift  = 1'b1;
            state_n    = SEND;
            tx_start_n = 1'b1;
            data_n     = ser_next;
`ifdef DEBUG_TX_CHECKSUM_EN
            csum_n     = csum_q ^ ser_next;
`endif
          end else if (o_control_database != LAST_WORD) begin
            word_n  = o_control_database + 1'b1;
            state_n = SELECT;
          end else begin
`ifdef DEBUG_TX_CHECKSUM_EN
            state_n    = CHECKSUM;
            tx_start_n = 1'b1;
            data_n     = csum_q;
`else
            state_n = DONE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            word_n  = '0;
`endif
          end
        end
      end
`ifdef DEBUG_TX_CHECKSUM_EN
      // The strobe cycle of the checksum byte behaves like SEND: tx_done ignored.
      CHECKSUM: begin
        if (!o_tx_start && i_tx_done) begin
          state_n = DONE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          word_n  = '0;
        end
      end
`endif
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_debug_tx_sequencer.sv
// Directed bench for debug_tx_sequencer with a registered database model and
// a tx model that returns i_tx_done 10 cycles after every o_tx_start.
module tb_debug_tx_sequencer;
  import debug_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        tx_done_m = 1'b0;
  logic        tx_done_x = 1'b0;
  logic        tx_done;
  logic [31:0] db_q = '0;
  logic [2:0]  ctrl;
  logic        tx_start;
  logic [7:0]  data_tx;
  logic        busy;
  logic        done;

  logic [31:0] mem [4];
  logic [7:0]  got_q [$];
  logic [7:0]  exp_q [$];
  int          pending  = 0;
  int          done_cnt = 0;
  int          total    = 0;
  int          bad      = 0;

  always #5 clk = ~clk;
  assign tx_done = tx_done_m | tx_done_x;

  debug_tx_sequencer #(
    .LONGITUD_INSTRUCCION(32),
    .OUTPUT_WORD_LENGTH  (8),
    .CANT_BITS_CONTROL   (3),
    .CANT_DATOS          (4)
  ) dut (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_start           (start),
    .i_tx_done         (tx_done),
    .i_dato_database   (db_q),
    .o_control_database(ctrl),
    .o_tx_start        (tx_start),
    .o_data_tx         (data_tx),
    .o_busy            (busy),
    .o_done            (done)
  );

  always @(posedge clk) db_q <= (ctrl < 3'd4) ? mem[ctrl[1:0]] : 32'h0;

  always @(negedge clk) begin
    tx_done_m = 1'b0;
    if (pending > 0) begin
      pending--;
      if (pending == 0) tx_done_m = 1'b1;
    end
    if (tx_start) begin
      got_q.push_back(data_tx);
      pending = 10;
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_log();
    got_q.delete();
    done_cnt = 0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) tick();
    if (done_cnt == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    for (int i = 0; i < 15; i++) tick();
  endtask

  task automatic wait_bytes(input string tag, input int n);
    for (int i = 0; i < 3000 && got_q.size() < n; i++) tick();
    if (got_q.size() < n) check({tag, "_timeout"}, 32'(got_q.size()), 32'(n));
  endtask

  task automatic check_dump(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"},     32'(ctrl),     32'd0);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_data_tx"},  32'(data_tx),  32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
  endtask

  initial begin
    logic [7:0] x;
    int inj;
    mem[DB_PC]          = 32'h11223344;
    mem[DB_ADDER_PC]    = 32'h55667788;
    mem[DB_CICLOS]      = 32'hAABBCCDD;
    mem[DB_INSTRUCTION] = 32'h00000001;
    exp_q = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
              8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h01, 8'h00, 8'h00, 8'h00};
`ifdef DEBUG_TX_CHECKSUM_EN
    x = 8'h00;
    foreach (exp_q[i]) x = x ^ exp_q[i];
    exp_q.push_back(x);
`endif
    rst   = 1'b1;
    start = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Basic dump with latency checks (start sampled at end of cycle 0).
    clear_log();
    pulse_start();
    check("lat_busy_c1", 32'(busy), 32'd1);
    check("lat_ctrl_c1", 32'(ctrl), 32'd0);
    tick();
    check("lat_txs_c2", 32'(tx_start), 32'd0);
    tick();
    check("lat_txs_c3", 32'(tx_start), 32'd1);
    check("lat_data_c3", 32'(data_tx), 32'h44);
    tick();
    check("lat_txs_c4", 32'(tx_start), 32'd0);
    wait_done("basic");
    check_dump("basic");

    // i_start mid-dump must be ignored.
    clear_log();
    pulse_start();
    wait_bytes("mid", 5);
    pulse_start();
    wait_done("mid");
    check_dump("mid");

    // Spurious tx_done in SELECT and in SEND cycles.
    clear_log();
    pulse_start();
    tx_done_x = 1'b1;
    tick();
    tx_done_x = 1'b0;
    inj = 0;
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      tick();
      if (tx_start && inj < 6) begin
        tx_done_x = 1'b1;
        inj++;
        tick();
        tx_done_x = 1'b0;
      end
    end
    if (done_cnt == 0) check("spur_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 15; i++) tick();
    check_dump("spur");

    // Async reset while waiting on byte 7, then a clean full dump.
    clear_log();
    pulse_start();
    wait_bytes("rst", 7);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("midrst_no_tx", 32'(got_q.size()), 32'd7);
    clear_log();
    pulse_start();
    check("after_rst_ctrl", 32'(ctrl), 32'd0);
    wait_done("after_rst");
    check_dump("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
